// File: rtl/trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : trng_word_packer
// Brief    : Packs the accepted TRNG bits into words LSB-first, queues them
//            in a small FIFO, and runs a repetition-count health test.
// Revision : 1.0 - initial release
// ============================================================================
module trng_word_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_valid,
    input  logic                          bit_in,
    input  logic                          clear,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [WORD_W-1:0]             word_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic                          health_fail
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int c_BIT_W = $clog2(WORD_W);
    localparam int c_RUN_W = $clog2(REP_LIMIT + 1);

    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(WORD_W - 1);
    localparam logic [c_RUN_W-1:0] c_REP_LIMIT = c_RUN_W'(REP_LIMIT);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

    logic [WORD_W-2:0]   r_shift;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_RUN_W-1:0]  r_run;
    logic                r_last_bit;
    logic                r_health_fail;

    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic [15:0]         r_drop_count;

    logic                w_accept;
    logic [c_RUN_W-1:0]  w_run_next;
    logic                w_trip;
    logic                w_pack;
    logic                w_push;
    logic [WORD_W-1:0]   w_word;
    logic                w_pop;
    logic                w_drop;
    logic                w_write;

    assign w_accept   = bit_valid && !r_health_fail && !clear;
    // A run restarts on the first bit after reset/clear or on any bit change.
    assign w_run_next = (r_run == '0 || bit_in != r_last_bit) ? c_RUN_W'(1)
                                                              : r_run + c_RUN_W'(1);
    assign w_trip     = w_accept && (w_run_next == c_REP_LIMIT);
    assign w_pack     = w_accept && !w_trip;
    assign w_word     = {bit_in, r_shift};
    assign w_push     = w_pack && (r_bit_cnt == c_LAST_BIT);
    assign w_pop      = (r_count != '0) && word_ready;
    assign w_drop     = w_push && (r_count == c_DEPTH) && !w_pop;
    assign w_write    = w_push && !w_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_run         <= '0;
            r_last_bit    <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (clear) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_run         <= '0;
            r_last_bit    <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            if (w_accept) begin
                r_run      <= w_run_next;
                r_last_bit <= bit_in;
            end
            if (w_trip) begin
                r_health_fail <= 1'b1;
                r_bit_cnt     <= '0;
            end else if (w_pack) begin
                r_shift   <= w_word[WORD_W-1:1];
                r_bit_cnt <= w_push ? '0 : r_bit_cnt + c_BIT_W'(1);
            end
        end
    end

    // When full with a pop, the write lands on the slot being popped this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_write) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign word_valid  = (r_count != '0);
    assign word_data   = r_mem[r_rd_ptr];
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;
    assign health_fail = r_health_fail;

endmodule
`default_nettype wire

// File: tb/tb_trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_word_packer
// Brief    : Directed bench for trng_word_packer with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_word_packer;

    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int REP_LIMIT  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        clear = 1'b0;
    logic        word_ready = 1'b0;
    logic        word_valid;
    logic [7:0]  word_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        health_fail;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;

    trng_word_packer #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .REP_LIMIT  (REP_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .clear       (clear),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bit list for the partial word, word queue for the FIFO.
    bit         m_bits[$];
    logic [7:0] m_fifo[$];
    int         m_run = 0;
    bit         m_last = 1'b0;
    bit         m_hf = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_drop = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_bits.delete();
            m_fifo.delete();
            m_run = 0; m_last = 1'b0; m_hf = 1'b0; m_ovf = 1'b0; m_drop = 0;
        end else begin
            bit         push;
            bit         pop;
            logic [7:0] w;
            push = 1'b0;
            w    = '0;
            pop  = (m_fifo.size() > 0) && word_ready;
            if (clear) begin
                m_bits.delete();
                m_run = 0; m_last = 1'b0; m_hf = 1'b0; m_ovf = 1'b0; m_drop = 0;
            end else if (bit_valid && !m_hf) begin
                m_run  = (m_run > 0 && bit_in == m_last) ? m_run + 1 : 1;
                m_last = bit_in;
                if (m_run == REP_LIMIT) begin
                    m_hf = 1'b1;
                    m_bits.delete();
                end else begin
                    m_bits.push_back(bit_in);
                    if (m_bits.size() == WORD_W) begin
                        for (int i = 0; i < WORD_W; i++) w[i] = m_bits[i];
                        m_bits.delete();
                        push = 1'b1;
                    end
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (push) begin
                if (m_fifo.size() == FIFO_DEPTH) begin
                    m_ovf = 1'b1;
                    if (m_drop < 16'hFFFF) m_drop++;
                end else begin
                    m_fifo.push_back(w);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("word_valid", {31'd0, word_valid}, {31'd0, m_fifo.size() > 0});
        if (m_fifo.size() > 0) chk("word_data", {24'd0, word_data}, {24'd0, m_fifo[0]});
        chk("fifo_count", {29'd0, fifo_count}, m_fifo.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {16'd0, drop_count}, m_drop);
        chk("health_fail", {31'd0, health_fail}, {31'd0, m_hf});
        if (reset && word_valid && word_ready) pop_cnt++;
    end

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_q [4];
        int         p0;
        reset = 1'b0;
        #1;
        chk("reset_valid", {31'd0, word_valid}, 0);
        chk("reset_count", {29'd0, fifo_count}, 0);
        chk("reset_drop", {16'd0, drop_count}, 0);
        idle(3);
        reset = 1'b1;
        idle(1);

        // 1: back-to-back bits 1,0,1,1,0,0,1,0
        word_ready = 1'b1;
        pat = 8'h4D;
        send_word(pat);
        chk("t1_valid", {31'd0, word_valid}, 1);
        chk("t1_data", {24'd0, word_data}, 32'h4D);
        idle(1);
        chk("t1_popped", {31'd0, word_valid}, 0);

        // 2: same bits with 0..3 idle cycles between them, reader stalled
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[i]);
            if (i < 7) idle(i % 4);
        end
        chk("t2_data", {24'd0, word_data}, 32'h4D);
        chk("t2_count", {29'd0, fifo_count}, 1);
        word_ready = 1'b1;
        idle(2);

        // 3: five words into a four-deep FIFO with the reader stalled
        word_ready = 1'b0;
        send_word(8'hAA); send_word(8'h55); send_word(8'hAA);
        send_word(8'h55); send_word(8'hAA);
        chk("t3_count", {29'd0, fifo_count}, 4);
        chk("t3_overflow", {31'd0, overflow}, 1);
        chk("t3_drop", {16'd0, drop_count}, 1);
        word_ready = 1'b1;
        exp_q = '{8'hAA, 8'h55, 8'hAA, 8'h55};
        for (int i = 0; i < 4; i++) begin
            chk("t3_read", {24'd0, word_data}, {24'd0, exp_q[i]});
            idle(1);
        end
        chk("t3_empty", {29'd0, fifo_count}, 0);
        pulse_clear();

        // 4: last bit of a word lands on the same edge as a pop from a full FIFO
        word_ready = 1'b0;
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        pat = 8'h55;
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        word_ready = 1'b1;
        send_bit(pat[7]);
        word_ready = 1'b0;
        chk("t4_count", {29'd0, fifo_count}, 4);
        chk("t4_drop", {16'd0, drop_count}, 0);
        word_ready = 1'b1;
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            chk("t4_read", {24'd0, word_data}, {24'd0, exp_q[i]});
            idle(1);
        end
        pulse_clear();

        // 5: 32 ones trip the repetition test
        p0 = pop_cnt;
        for (int i = 0; i < 31; i++) send_bit(1'b1);
        chk("t5_hf_before", {31'd0, health_fail}, 0);
        send_bit(1'b1);
        chk("t5_hf", {31'd0, health_fail}, 1);
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        idle(2);
        chk("t5_words", pop_cnt - p0, 3);
        chk("t5_empty", {29'd0, fifo_count}, 0);
        pulse_clear();
        chk("t5_hf_clr", {31'd0, health_fail}, 0);
        word_ready = 1'b0;
        send_word(8'hA5);
        chk("t5_new", {24'd0, word_data}, 32'hA5);
        word_ready = 1'b1;
        idle(2);

        // 6: async reset in the middle of a word
        word_ready = 1'b0;
        send_word(8'h81);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("t6_pre", {29'd0, fifo_count}, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", {31'd0, word_valid}, 0);
        chk("t6_count", {29'd0, fifo_count}, 0);
        chk("t6_data", {24'd0, word_data}, 0);
        idle(2);
        reset = 1'b1;
        send_word(8'h3C);
        chk("t6_word", {24'd0, word_data}, 32'h3C);
        chk("t6_cnt1", {29'd0, fifo_count}, 1);
        word_ready = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
